// File: rtl/controller.sv
// March-test BIST sequencer: drives an external address counter and memory write enable.
// Optional `BIST_STOP_ON_FAIL_EN` ends the test at the first read mismatch.
module controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_equal,
  input  logic carry,
  output logic out,
  output logic reset,
  output logic preset,
  output logic en,
  output logic up_down,
  output logic fail,
  output logic done
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR0 = 4'd1,
    S_W0   = 4'd2,
    S_CLR1 = 4'd3,
    S_R0   = 4'd4,
    S_PRE0 = 4'd5,
    S_W1   = 4'd6,
    S_PRE1 = 4'd7,
    S_R1   = 4'd8,
    S_DONE = 4'd9
  } state_t;

`ifdef BIST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        fail_q, fail_d;
  logic [5:0]  outs_q;

  // Output vector order: {out, reset, preset, en, up_down, done}
  function automatic logic [5:0] decode(input state_t s);
    logic [5:0] v;
    case (s)
      S_CLR0, S_CLR1: v = 6'b010000;
      S_W0:           v = 6'b100110;
      S_R0:           v = 6'b000110;
      S_PRE0, S_PRE1: v = 6'b001000;
      S_W1:           v = 6'b100100;
      S_R1:           v = 6'b000100;
      S_DONE:         v = 6'b000001;
      default:        v = 6'b000000;
    endcase
    return v;
  endfunction

  // Next-state and sticky fail computation
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR0;
          fail_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR0: state_d = S_W0;
      S_W0: begin
        if (carry) begin
          state_d = S_CLR1;
        end else begin
          state_d = S_W0;
        end
      end
      S_CLR1: state_d = S_R0;
      S_R0: begin
        if (carry) begin
          state_d = S_PRE0;
        end else begin
          state_d = S_R0;
        end
        // A mismatch on the terminal address still counts
        if (!is_equal) begin
          fail_d = 1'b1;
          if (STOP_ON_FAIL) begin
            state_d = S_DONE;
          end else begin
            fail_d = 1'b1;
          end
        end else begin
          fail_d = fail_q;
        end
      end
      S_PRE0: state_d = S_W1;
      S_W1: begin
        if (carry) begin
          state_d = S_PRE1;
        end else begin
          state_d = S_W1;
        end
      end
      S_PRE1: state_d = S_R1;
      S_R1: begin
        if (carry) begin
          state_d = S_DONE;
        end else begin
          state_d = S_R1;
        end
        if (!is_equal) begin
          fail_d = 1'b1;
          if (STOP_ON_FAIL) begin
            state_d = S_DONE;
          end else begin
            fail_d = 1'b1;
          end
        end else begin
          fail_d = fail_q;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        fail_d  = 1'b0;
      end
    endcase
  end

  // State, fail flag and outputs registered together so outputs track the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fail_q  <= 1'b0;
      outs_q  <= 6'b000000;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      outs_q  <= decode(state_d);
    end
  end

  assign out     = outs_q[5];
  assign reset   = outs_q[4];
  assign preset  = outs_q[3];
  assign en      = outs_q[2];
  assign up_down = outs_q[1];
  assign done    = outs_q[0];
  assign fail    = fail_q;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: 16-address counter + 1-bit memory model, random fault injection,
// expected per-cycle outputs derived from the march-pass layout.
module tb_controller;

  logic clk = 1'b0;
  logic rst, start, is_equal, carry;
  logic out, reset, preset, en, up_down, fail, done;

  int checks = 0;
  int failures = 0;

  logic [3:0] cnt;
  logic       mem [16];
  logic       fault_en, fault_up;
  logic [3:0] fault_addr;
  logic [6:0] obs;

  controller dut (
    .clk(clk), .rst(rst), .start(start), .is_equal(is_equal), .carry(carry),
    .out(out), .reset(reset), .preset(preset), .en(en), .up_down(up_down),
    .fail(fail), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: address counter and memory
  always @(posedge clk) begin
    if (reset) cnt <= 4'd0;
    else if (preset) cnt <= 4'd15;
    else if (en) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    if (en && out) mem[cnt] <= ~up_down;
  end

  assign carry = up_down ? (cnt == 4'd15) : (cnt == 4'd0);
  assign is_equal = (mem[cnt] == ~up_down) &&
                    !(fault_en && en && !out && (up_down == fault_up) && (cnt == fault_addr));
  assign obs = {out, reset, preset, en, up_down, done, fail};

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {out,reset,preset,en,up_down,done,fail} at cycle p after the start-sampling edge
  function automatic logic [6:0] exp_vec(input int p, input int fpos);
    logic [6:0] v;
    logic f;
    f = (fpos >= 0) && (p > fpos);
`ifdef BIST_STOP_ON_FAIL_EN
    if (f) return {6'b000001, 1'b1};
`endif
    if (p == 0 || p == 17)      v = 7'b0100000;
    else if (p <= 16)           v = 7'b1001100;
    else if (p <= 33)           v = 7'b0001100;
    else if (p == 34 || p == 51) v = 7'b0010000;
    else if (p <= 50)           v = 7'b1001000;
    else if (p <= 67)           v = 7'b0001000;
    else                        v = 7'b0000010;
    return v | {6'b000000, f};
  endfunction

  // fpass: 0 none, 1 R0 (address fidx), 2 R1 (fidx-th read, address 15-fidx)
  task automatic run(input int id, input int fpass, input int fidx, input int last_pos,
                     input int drop_at);
    int fpos;
    fault_en   = (fpass != 0);
    fault_up   = (fpass == 1);
    fault_addr = (fpass == 1) ? 4'(fidx) : 4'(15 - fidx);
    fpos = (fpass == 1) ? 18 + fidx : (fpass == 2) ? 52 + fidx : -1;
    for (int p = 0; p <= last_pos; p++) begin
      if (p == drop_at) start = 1'b0;
      if (drop_at >= 0 && p == drop_at + 40) start = 1'b1;
      step();
      check($sformatf("run%0d_p%0d", id, p), obs, exp_vec(p, fpos));
    end
    fault_en = 1'b0;
  endtask

  initial begin
    int idx;
    cnt = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 1'($urandom);
    fault_en = 1'b0; fault_up = 1'b0; fault_addr = 4'd0;
    rst = 1'b1; start = 1'b1;

    repeat (2) begin
      step();
      check("reset_hold", obs, 7'b0000000);
    end
    rst = 1'b0;

    // Good memory, start held through DONE, start dropped briefly mid-test
    run(1, 0, 0, 72, 10);
    start = 1'b0; step(); check("idle_after_good", obs, 7'b0000000);

    // Stuck-at mismatch in R0
    start = 1'b1;
    idx = int'($urandom_range(0, 15));
    run(2, 1, idx, 70, -1);
    start = 1'b0; step(); check("idle_after_r0", obs, 7'b0000001);

    // Mismatch only on the terminal R1 address; fail cleared on restart
    start = 1'b1;
    run(3, 2, 15, 70, -1);
    start = 1'b0; step(); check("idle_after_r1t", obs, 7'b0000001);

    // Random R1 mismatch
    start = 1'b1;
    idx = int'($urandom_range(0, 14));
    run(4, 2, idx, 70, -1);
    start = 1'b0; step(); check("idle_after_r1", obs, 7'b0000001);

    // Mid-test reset during W1 after an R0 mismatch
    start = 1'b1;
    idx = int'($urandom_range(0, 15));
    run(5, 1, idx, 35 + int'($urandom_range(0, 15)), -1);
    rst = 1'b1; step(); check("mid_reset", obs, 7'b0000000);
    rst = 1'b0;
    run(6, 0, 0, 70, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller.md
# controller

Memory built-in self-test (BIST) sequencer. On `start` it runs a four-pass march test over an external address counter and memory/comparator datapath, then reports pass/fail. It drives the counter controls (`reset`, `preset`, `en`, `up_down`) and the memory write enable (`out`). It samples the comparator (`is_equal`) and the counter terminal-count flag (`carry`).

## Interface
- No parameters. Counter width lives in the datapath; the controller relies only on `carry`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level request to run the test; sampled in IDLE.
- `is_equal` input 1: comparator result, memory readback equals the expected pattern.
- `carry` input 1: counter terminal count, combinational. All-ones when counting up, zero when counting down.
- `out` output 1: memory write enable. 1 = write pattern, 0 = read and compare.
- `reset` output 1: synchronous clear of the address counter to 0.
- `preset` output 1: synchronous load of the address counter to all-ones.
- `en` output 1: counter count enable.
- `up_down` output 1: count direction, 1 = up, 0 = down. It also selects the data pattern: up passes use 0, down passes use 1.
- `fail` output 1: sticky mismatch flag.
- `done` output 1: test complete.

## Operation
- Moore FSM. Outputs are decoded from the state register, except `fail`, which is its own register.
- States and outputs (signals not listed are 0):
  - IDLE: all outputs 0 except the held `fail`.
  - CLR0: `reset`=1.
  - W0: `en`=1, `up_down`=1, `out`=1 (write 0s ascending).
  - CLR1: `reset`=1.
  - R0: `en`=1, `up_down`=1, `out`=0 (read/expect 0s ascending).
  - PRE0: `preset`=1.
  - W1: `en`=1, `up_down`=0, `out`=1 (write 1s descending).
  - PRE1: `preset`=1.
  - R1: `en`=1, `up_down`=0, `out`=0 (read/expect 1s descending).
  - DONE: `done`=1.
- Transitions:
  - IDLE→CLR0 when `start`=1.
  - CLR0→W0, CLR1→R0, PRE0→W1 and PRE1→R1 are unconditional.
  - Each of W0, R0, W1, R1 stays put while `carry`=0 and advances on `carry`=1, in the order W0→CLR1, R0→PRE0, W1→PRE1, R1→DONE. The cycle with `carry`=1 is the last address processed in that pass.
  - DONE→IDLE when `start`=0.
- Fail detection: in R0 or R1, `is_equal`=0 at a clock edge sets `fail`.
  - `fail` clears on the IDLE→CLR0 transition.
  - Otherwise `fail` holds until `rst`.
  - `is_equal` is ignored in all other states.
- Boundary cases:
  - `start` held high through DONE does not retrigger; it must drop to 0 before a rerun.
  - `start` dropping mid-test has no effect.
  - A mismatch on the `carry` cycle of R1 still sets `fail`.
  - `rst` at any point returns to IDLE with all outputs 0.

## Timing
- Reset value: state IDLE; `out`, `reset`, `preset`, `en`, `up_down`, `fail`, `done` are all 0.
- Start latency: the edge that samples `start`=1 in IDLE enters CLR0, so `reset` is high for the following cycle.
- For an N-address counter, a full run occupies 4 + 4N cycles from CLR0 entry to DONE entry. With N=16 that is 68 cycles, so `done` rises 68 clocks after the start-sampling edge.
- `fail` updates at the edge that samples the mismatch, so it is visible one cycle later.

## Configuration
- `BIST_STOP_ON_FAIL_EN` defined: a mismatch in R0/R1 sets `fail` and goes directly to DONE at the same edge, skipping the remaining passes.
- `BIST_STOP_ON_FAIL_EN` undefined (default): the test always completes all four passes; `fail` is sticky.

## Test plan
- Reset hold: `rst`=1 for 2 cycles with `start`=1 -> all outputs 0, state IDLE. Release `rst` -> CLR0 entered at the next edge.
- Good memory: 4-bit counter model and ideal memory, `start`=1 -> pass order CLR0, W0(16), CLR1, R0(16), PRE0, W1(16), PRE1, R1(16); `done`=1 at cycle 68; `fail`=0.
- Stuck-at fault: force `is_equal`=0 at address 5 during R0.
  - Macro undefined -> `fail`=1 from the next cycle and `done` at cycle 68.
  - Macro defined -> DONE entered at that edge.
- Terminal-address mismatch: `is_equal`=0 only on the `carry` cycle of R1 -> `fail`=1, `done`=1.
- Rerun: after DONE, drop `start` for 1 cycle then raise it -> IDLE, then CLR0; `fail` cleared; full sequence repeats.
- Mid-test reset: assert `rst` during W1 -> next cycle in IDLE, all outputs 0; `start` still high -> restart at CLR0.
